mem_block_responder: RTL

Memory-side responder for cache block fills. It accepts a block read request from the cache fill controller and waits a fixed access latency. It then streams the eight 16-bit words of the 16-byte block, one per cycle, each qualified by `data_valid`. It also accepts single-word write-through stores at any time, with forwarding into an in-flight stream.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/mem_word_array.sv | 63 ++++++
 rtl/mem_block_responder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared constants for the memory-side block responder:
//   - 2-bit FSM state encoding (IDLE / WAIT / STREAM / DONE)
//   - block geometry: 8 words of 16 bits = 16 bytes per block
//   - helper that forms the byte address of one beat inside a block
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_WAIT   = 2'd1;
    localparam state_t ST_STREAM = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    localparam int BLOCK_WORDS    = 8;
    localparam int BEAT_W         = 3;
    localparam int BLOCK_OFFSET_W = 4;

    // Byte address of a beat: block base bits stay fixed, only the word
    // offset inside the 16-byte block moves, so the address never leaves
    // the block.
    function automatic logic [15:0] beat_byte_addr(
        input logic [15-BLOCK_OFFSET_W:0] base,
        input logic [BEAT_W-1:0]          beat
    );
        return {base, beat, 1'b0};
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// -----------------------------------------------------------------------------
// mem_word_array
// Backing store of 2^AW words of DW bits.
//   clk_i       clock
//   rst_ni      asynchronous active-low reset (read register only; the
//               storage itself is never reset)
//   wr_en_i     write strobe, word written at the rising edge
//   wr_addr_i   word address of the write
//   wr_data_i   write data
//   rd_en_i     read enable; the read register only updates when high,
//               otherwise it holds its last value
//   rd_addr_i   word address of the read
//   rd_data_o   registered read data
// A write and a read of the same word at the same edge return the new data,
// so a store is never lost to a read that was already in flight.
// -----------------------------------------------------------------------------
module mem_word_array #(
    parameter int AW = 15,
    parameter int DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] rd_data_d;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Same-edge write-to-read forwarding.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
                rd_data_d = wr_data_i;
            end else begin
                rd_data_d = mem_q[rd_addr_i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mem_block_responder.sv
// -----------------------------------------------------------------------------
// mem_block_responder
// Memory-side responder for cache block fills. After a block request is
// accepted it waits LATENCY cycles, then returns the eight 16-bit words of
// the 16-byte block, one per cycle. Single-word stores are accepted in every
// state and are forwarded into a stream that is reading the same word.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   req         block read request (level), only looked at in IDLE
//   req_addr    byte address of the miss; block base = {req_addr[15:4], 4'h0}
//   wr_en       single-word write strobe
//   wr_addr     write byte address (bit 0 ignored)
//   wr_data     write data
//   data_out    returned word (registered)
//   data_addr   byte address of data_out (registered)
//   data_valid  high one cycle per returned word
//   busy        high whenever the FSM is not in IDLE
//   dbg_state   current FSM state (mem_pkg encoding)
//
// Handshake: there is no ready/ack. req is a level that is sampled only at
// an edge where the FSM is in IDLE; a request seen in any other state is
// dropped, never queued. The requester sees acceptance as busy rising.
//
// Timeline for an accept at edge E0: WAIT for LATENCY-1 cycles, STREAM for
// eight cycles (beat k registered at E0+LATENCY+k), then DONE, which is the
// cycle presenting the final beat while nothing new is registered. DONE
// always returns to IDLE and ignores req, so a held miss cannot restart a
// fill without passing through IDLE. Block period is LATENCY+9 cycles.
// -----------------------------------------------------------------------------
module mem_block_responder
    import mem_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int MEM_AW  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [15:0] req_addr,
    input  logic        wr_en,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic [15:0] data_out,
    output logic [15:0] data_addr,
    output logic        data_valid,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam int BASE_W = 16 - BLOCK_OFFSET_W;

    state_t                       state_q, state_d;
    logic [3:0]                   wait_cnt_q, wait_cnt_d;
    logic [BEAT_W-1:0]            beat_q, beat_d;
    logic [BASE_W-1:0]            base_q, base_d;
    logic [15:0]                  data_addr_q, data_addr_d;
    logic                         data_valid_q, data_valid_d;
    logic                         rd_en;
    logic [BASE_W+BEAT_W-1:0]     rd_word;

    // Word index of the beat being fetched this cycle.
    assign rd_word = {base_q, beat_q};

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        beat_d       = beat_q;
        base_d       = base_q;
        data_addr_d  = data_addr_q;
        data_valid_d = 1'b0;
        rd_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    base_d = req_addr[15:BLOCK_OFFSET_W];
                    beat_d = '0;
                    if (LATENCY == 1) begin
                        state_d = ST_STREAM;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = 4'(LATENCY - 1);
                    end
                end
            end

            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q == 4'd1) begin
                    state_d = ST_STREAM;
                end
            end

            ST_STREAM: begin
                // Each edge in STREAM registers one word and its address.
                rd_en        = 1'b1;
                data_valid_d = 1'b1;
                data_addr_d  = beat_byte_addr(base_q, beat_q);
                beat_d       = beat_q + BEAT_W'(1);
                if (beat_q == BEAT_W'(BLOCK_WORDS - 1)) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= '0;
            beat_q       <= '0;
            base_q       <= '0;
            data_addr_q  <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            beat_q       <= beat_d;
            base_q       <= base_d;
            data_addr_q  <= data_addr_d;
            data_valid_q <= data_valid_d;
        end
    end

    // The array's read register doubles as the data_out register: it only
    // loads while streaming, so data_out holds the last beat otherwise.
    mem_word_array #(
        .AW (MEM_AW),
        .DW (16)
    ) u_array (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr[MEM_AW:1]),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_word[MEM_AW-1:0]),
        .rd_data_o (data_out)
    );

    // Block-offset bits of the request and the byte-select bit of the write
    // address carry no information for a word-wide block fetch.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[BLOCK_OFFSET_W-1:0], wr_addr[0]};

    assign data_addr  = data_addr_q;
    assign data_valid = data_valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign dbg_state  = state_q;

endmodule
